// File: rtl/dmem_pkg.sv
// Shared widths, FSM state type and address-range helper for the data-memory arbiter.
package dmem_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    // True when any address bit above the physical RAM width is set.
    function automatic logic addr_oor(input logic [31:0] addr, input int aw);
        return (addr >> aw) != 32'd0;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on a tie the master not granted most recently wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 means master 1 was granted last, so reset value favours master 0.
    logic last_r;

    // Combinational pick from current requests and last-grant pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_r ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Last-grant pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_r <= gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-RAM arbiter: combinational grant in IDLE, reads complete two cycles after grant.
module dmem_arbiter #(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    import dmem_pkg::*;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic              grant_s;
    logic              sel_we_s;
    logic              sel_oor_s;
    logic [31:0]       sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              rd_master_r;
    logic              rd_oor_r;
    logic [1:0]        rvalid_r;
    logic [1:0]        err_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;

    assign req_s   = (state_r == ST_IDLE) ? {m1_req, m0_req} : 2'b00;
    assign grant_s = |gnt_s;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_s),
        .advance (grant_s),
        .gnt     (gnt_s)
    );

    // Route the granted master's request fields.
    always_comb begin
        if (gnt_s[1]) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
        end
        sel_oor_s = addr_oor(sel_addr_s, ADDR_W);
    end

    // RAM port drive; quiet when nothing is granted, writes suppressed when out of range.
    always_comb begin
        if (grant_s) begin
            ram_addr = sel_addr_s[ADDR_W-1:0];
            ram_din  = sel_wdata_s;
            ram_we   = sel_we_s & ~sel_oor_s;
        end else begin
            ram_addr = {ADDR_W{1'b0}};
            ram_din  = {DATA_W{1'b0}};
            ram_we   = 1'b0;
        end
    end

    // Next-state logic: a granted read spends one cycle in RD_WAIT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s && !sel_we_s) begin
                    state_nxt_s = ST_RD_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus owner/range of the outstanding read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rd_master_r <= 1'b0;
            rd_oor_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (grant_s && !sel_we_s) begin
                rd_master_r <= gnt_s[1];
                rd_oor_r    <= sel_oor_s;
            end
        end
    end

    // Capture RAM data at the end of RD_WAIT; the other master's rdata holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_r <= 2'b00;
            err_r    <= 2'b00;
            rdata0_r <= {DATA_W{1'b0}};
            rdata1_r <= {DATA_W{1'b0}};
        end else begin
            rvalid_r <= 2'b00;
            err_r    <= 2'b00;
            if (state_r == ST_RD_WAIT) begin
                rvalid_r[rd_master_r] <= 1'b1;
                err_r[rd_master_r]    <= rd_oor_r;
                if (rd_master_r) begin
                    rdata1_r <= rd_oor_r ? {DATA_W{1'b0}} : ram_dout;
                end else begin
                    rdata0_r <= rd_oor_r ? {DATA_W{1'b0}} : ram_dout;
                end
            end
        end
    end

    assign m0_gnt    = gnt_s[0];
    assign m1_gnt    = gnt_s[1];
    assign m0_err    = (gnt_s[0] & sel_oor_s) | err_r[0];
    assign m1_err    = (gnt_s[1] & sel_oor_s) | err_r[1];
    assign m0_rvalid = rvalid_r[0];
    assign m1_rvalid = rvalid_r[1];
    assign m0_rdata  = rdata0_r;
    assign m1_rdata  = rdata1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural one-cycle-latency RAM.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = 32'd0, m1_addr = 32'd0;
    logic [31:0] m0_wdata = 32'd0, m1_wdata = 32'd0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [19:0] ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;

    typedef struct { bit m; bit we; bit oor; logic [31:0] addr; logic [31:0] wdata; } gexp_t;
    typedef struct { bit m; logic [31:0] data; bit oor; } rexp_t;

    gexp_t gnt_q[$];
    rexp_t rv_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    gap_exp = 0;

    dmem_arbiter #(.ADDR_W(20), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: contents preset on reset to 0xA5000000 | index.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
            ram_dout <= 32'd0;
        end else begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_din;
            ram_dout <= mem[ram_addr[7:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state.
    gexp_t       ge;
    rexp_t       re;
    logic [1:0]  exp_err, gv, rv;
    bit          pend_v = 1'b0;
    int          pend_cyc = 0;
    bit          gap_seen = 1'b0;
    int          last_gcyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            pend_v = 1'b0;
            chk("reset_outs", {26'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err}, 32'd0);
            chk("reset_rdata", m0_rdata | m1_rdata, 32'd0);
        end else begin
            exp_err = 2'b00;
            gv = {m1_gnt, m0_gnt};
            rv = {m1_rvalid, m0_rvalid};
            if (rv != 2'b00) begin
                if (rv_q.size() == 0) begin
                    chk("unexpected_rvalid", {30'd0, rv}, 32'd0);
                end else begin
                    re = rv_q.pop_front();
                    chk("rvalid_master", {30'd0, rv}, re.m ? 32'd2 : 32'd1);
                    chk("rdata", re.m ? m1_rdata : m0_rdata, re.data);
                    chk("rvalid_latency", cyc - pend_cyc, 32'd2);
                    if (re.oor) exp_err[re.m] = 1'b1;
                end
                pend_v = 1'b0;
            end else if (pend_v && (cyc >= pend_cyc + 2)) begin
                chk("missing_rvalid", 32'd0, 32'd1);
                pend_v = 1'b0;
            end
            if (gv != 2'b00) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_gnt", {30'd0, gv}, 32'd0);
                end else begin
                    ge = gnt_q.pop_front();
                    chk("gnt_master", {30'd0, gv}, ge.m ? 32'd2 : 32'd1);
                    chk("ram_we", {31'd0, ram_we}, {31'd0, ge.we & ~ge.oor});
                    if (!ge.oor) chk("ram_addr", {12'd0, ram_addr}, ge.addr);
                    if (ge.we) chk("ram_din", ram_din, ge.wdata);
                    if (ge.oor) exp_err[ge.m] = 1'b1;
                    if (!ge.we) begin
                        pend_v = 1'b1;
                        pend_cyc = cyc;
                    end
                end
                if (gap_exp != 0) begin
                    if (gap_seen) chk("gnt_gap", cyc - last_gcyc, gap_exp);
                    gap_seen = 1'b1;
                    last_gcyc = cyc;
                end
            end else begin
                chk("idle_ram", {11'd0, ram_we, ram_addr} | ram_din, 32'd0);
            end
            if (gap_exp == 0) gap_seen = 1'b0;
            chk("err", {30'd0, m1_err, m0_err}, {30'd0, exp_err});
        end
    end

    task automatic push_g(input bit m, input bit we, input bit oor, input logic [31:0] a, input logic [31:0] d);
        gexp_t g;
        g.m = m; g.we = we; g.oor = oor; g.addr = a; g.wdata = d;
        gnt_q.push_back(g);
    endtask

    task automatic push_r(input bit m, input logic [31:0] d, input bit oor);
        rexp_t r;
        r.m = m; r.data = d; r.oor = oor;
        rv_q.push_back(r);
    endtask

    // Present one request and hold it until granted (bounded).
    task automatic access(input bit m, input bit we, input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((m ? m1_gnt : m0_gnt) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (m) m1_req = 1'b0; else m0_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_timeout: master %0d got no gnt within 20 cycles, required a gnt", m);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (gnt_q.size() == 0 && rv_q.size() == 0 && !pend_v) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Both masters read continuously from reset: m0, m1, m0, m1, one grant per 2 cycles.
        gap_exp = 2;
        push_g(0, 0, 0, 32'h5, 32'h0); push_r(0, 32'hA500_0005, 0);
        push_g(1, 0, 0, 32'h6, 32'h0); push_r(1, 32'hA500_0006, 0);
        push_g(0, 0, 0, 32'h5, 32'h0); push_r(0, 32'hA500_0005, 0);
        push_g(1, 0, 0, 32'h6, 32'h0); push_r(1, 32'hA500_0006, 0);
        fork
            begin access(0, 0, 32'h5, 32'h0); access(0, 0, 32'h5, 32'h0); end
            begin access(1, 0, 32'h6, 32'h0); access(1, 0, 32'h6, 32'h0); end
        join
        drain();
        gap_exp = 0;
        @(posedge clk); #1;

        // m0 write then read back 0x10.
        push_g(0, 1, 0, 32'h10, 32'hDEAD_BEEF);
        access(0, 1, 32'h10, 32'hDEAD_BEEF);
        push_g(0, 0, 0, 32'h10, 32'h0); push_r(0, 32'hDEAD_BEEF, 0);
        access(0, 0, 32'h10, 32'h0);
        drain();

        // m1 out-of-range write must not touch RAM word 0.
        push_g(1, 1, 1, 32'h0010_0000, 32'h1234_5678);
        access(1, 1, 32'h0010_0000, 32'h1234_5678);
        push_g(0, 0, 0, 32'h0, 32'h0); push_r(0, 32'hA500_0000, 0);
        access(0, 0, 32'h0, 32'h0);
        drain();

        // m0 out-of-range read returns zero with err at grant and at rvalid.
        push_g(0, 0, 1, 32'h2000_0000, 32'h0); push_r(0, 32'h0, 1);
        access(0, 0, 32'h2000_0000, 32'h0);
        drain();

        // Back-to-back m1 writes to 0x1..0x4, then read them back.
        gap_exp = 1;
        for (int i = 1; i <= 4; i++) push_g(1, 1, 0, i, 32'hB000_0000 + i);
        for (int i = 1; i <= 4; i++) access(1, 1, i, 32'hB000_0000 + i);
        drain();
        gap_exp = 0;
        for (int i = 1; i <= 4; i++) begin
            push_g(0, 0, 0, i, 32'h0); push_r(0, 32'hB000_0000 + i, 0);
            access(0, 0, i, 32'h0);
        end
        drain();

        // Reset during the RD_WAIT cycle of an m1 read: no rvalid afterward.
        push_g(1, 0, 0, 32'h7, 32'h0);
        access(1, 0, 32'h7, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;

        // First post-reset tie goes to m0.
        push_g(0, 0, 0, 32'h3, 32'h0); push_r(0, 32'hA500_0003, 0);
        push_g(1, 0, 0, 32'h8, 32'h0); push_r(1, 32'hA500_0008, 0);
        fork
            access(0, 0, 32'h3, 32'h0);
            access(1, 0, 32'h8, 32'h0);
        join
        drain();

        chk("gnt_q_empty", gnt_q.size(), 32'd0);
        chk("rv_q_empty", rv_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20: physical data-RAM address width in words.
REQ-002 Parameter DATA_W, default 32: data width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 m0_req, m1_req  in  1  access request from master 0 (CPU load/store) and master 1 (loader/IO).
REQ-006 m0_we, m1_we  in  1  1 = write, 0 = read; sampled with req.
REQ-007 m0_addr, m1_addr  in  32  word address; bits [31:ADDR_W] must be zero.
REQ-008 m0_wdata, m1_wdata  in  DATA_W  write data.
REQ-009 m0_gnt, m1_gnt  out  1  one-cycle pulse: request accepted this cycle.
REQ-010 m0_rvalid, m1_rvalid  out  1  one-cycle pulse: read data valid.
REQ-011 m0_rdata, m1_rdata  out  DATA_W  read data, valid only with rvalid.
REQ-012 m0_err, m1_err  out  1  one-cycle pulse: out-of-range access.
REQ-013 ram_addr  out  ADDR_W  RAM address.
REQ-014 ram_din  out  DATA_W  RAM write data.
REQ-015 ram_we  out  1  RAM write enable.
REQ-016 ram_dout  in  DATA_W  RAM read data, valid one cycle after the address is presented.

Function
REQ-017 States: IDLE (may grant), RD_WAIT (one RAM read outstanding, no grant).
REQ-018 Master holds req, we, addr and wdata stable from assertion until gnt is seen; the arbiter samples them in the grant cycle only.
REQ-019 In IDLE with a request pending, the arbiter grants one master combinationally in that cycle (cycle N) and drives ram_addr/ram_din/ram_we from it.
REQ-020 Single requester: that master is granted; both requesting: the master not granted most recently wins; after reset, master 0 wins the first tie.
REQ-021 Write granted in cycle N: ram_we = 1 in cycle N only; the FSM stays in IDLE; a new grant is possible in N+1.
REQ-022 Read granted in cycle N: the FSM enters RD_WAIT at N+1; ram_dout is registered at the end of N+1; rvalid/rdata of the granted master are asserted in N+2.
REQ-023 The FSM returns to IDLE in N+2 and may grant a new request in that same cycle; peak read throughput is one per 2 cycles.
REQ-024 Out-of-range (addr[31:ADDR_W] != 0): still granted; ram_we forced 0; err pulses in the grant cycle.
REQ-025 Out-of-range read follows REQ-022 timing but returns rdata = 0; err also pulses with rvalid.
REQ-026 When no grant occurs: ram_we = 0, ram_addr = 0, ram_din = 0.
REQ-027 Only the granted master's gnt/rvalid/err may assert; the other master's rdata is held at its previous value.

Reset
REQ-028 rst asserted at any time returns the FSM to IDLE, clears the last-grant pointer to favour master 0, and zeroes all registered outputs (rvalid, rdata, err).
REQ-029 A read outstanding when rst asserts is discarded; no rvalid is produced for it after rst deasserts.

Structure
REQ-030 Package dmem_pkg holds ADDR_W, DATA_W and the FSM state type.
REQ-031 Sub-module rr_arb2 is a 2-way round-robin picker (req[1:0], advance -> gnt[1:0], last-grant flop).
REQ-032 The RAM itself is outside this block; the arbiter is purely an ordering and routing layer.

Verification
REQ-033 m0 writes addr 0x10 = 0xDEADBEEF, then reads 0x10 -> m0_gnt pulses in both access cycles; m0_rvalid two cycles after the read grant with rdata 0xDEADBEEF.
REQ-034 m0 and m1 both read continuously from reset -> grants alternate m0, m1, m0 with a grant every 2 cycles; no rvalid goes to the wrong master.
REQ-035 m1 writes addr 0x0010_0000 -> m1_gnt and m1_err pulse together, ram_we stays 0, and a later read of 0x0 is unchanged.
REQ-036 m0 reads 0x2000_0000 -> m0_err at the grant; m0_rvalid with rdata 0 and m0_err two cycles later.
REQ-037 rst asserted in the RD_WAIT cycle of an m1 read -> no m1_rvalid afterward; the first post-reset tie is granted to m0.
REQ-038 Back-to-back m1 writes to 0x1..0x4 with m0 idle -> four consecutive gnt cycles, RAM contents verified by reads.
